// File: rtl/pixel_streamer.sv
// Frame-buffer source for the image filter: host loads a WIDTH x DEPTH frame, then each
// start streams it one pixel/clock and holds proc_en until finish_in. Optional stall: PIXEL_STREAMER_STALL_EN.
module pixel_streamer #(
  parameter int WIDTH  = 410,
  parameter int DEPTH  = 361,
  parameter int ADDR_W = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              start,
  input  logic              finish_in,
`ifdef PIXEL_STREAMER_STALL_EN
  input  logic              stall,
`endif
  output logic [7:0]        pix_out,
  output logic              pix_valid,
  output logic              proc_en,
  output logic              busy,
  output logic              done
);

  localparam int NPIX = WIDTH * DEPTH;
  localparam int XW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   NPIX_W = (ADDR_W+1)'(NPIX);
  localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(NPIX - 1);
  localparam logic [XW-1:0]     X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0]     Y_LAST = YW'(DEPTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_PRIME, S_STREAM, S_PROCESS, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic              pix_valid_q, pix_valid_d;
  logic              loaded_q, loaded_d;
  logic              load;
  logic              stall_w;
  logic [7:0]        rd_q;
  logic [7:0]        mem [NPIX];

`ifdef PIXEL_STREAMER_STALL_EN
  assign stall_w = stall;
`else
  assign stall_w = 1'b0;
`endif

  // Frame buffer has no reset so its contents survive rst; writes only land while idle.
  always_ff @(posedge clk) begin
    if (wr_en && (state_q == S_IDLE) && ({1'b0, wr_addr} < NPIX_W))
      mem[wr_addr] <= wr_data;
    if (load)
      rd_q <= mem[cnt_q];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      pix_valid_q <= 1'b0;
      loaded_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      pix_valid_q <= pix_valid_d;
      loaded_q    <= loaded_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    x_d         = x_q;
    y_d         = y_q;
    pix_valid_d = 1'b0;
    loaded_d    = loaded_q;
    load        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_PRIME;
          cnt_d   = '0;
          x_d     = '0;
          y_d     = '0;
        end
      end
      S_PRIME: begin
        load        = 1'b1;
        loaded_d    = 1'b1;
        pix_valid_d = 1'b1;
        cnt_d       = (cnt_q == LAST) ? cnt_q : cnt_q + 1'b1;
        state_d     = S_STREAM;
      end
      S_STREAM: begin
        // x/y describe the pixel currently on pix_out; cnt_q is the next read address.
        if (stall_w) begin
          pix_valid_d = 1'b0;
        end else if ((x_q == X_LAST) && (y_q == Y_LAST)) begin
          state_d = S_PROCESS;
        end else begin
          load        = 1'b1;
          pix_valid_d = 1'b1;
          cnt_d       = (cnt_q == LAST) ? cnt_q : cnt_q + 1'b1;
          if (x_q == X_LAST) begin
            x_d = '0;
            y_d = y_q + 1'b1;
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      S_PROCESS: begin
        if (finish_in)
          state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        x_d     = '0;
        y_d     = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // pix_out reads as zero until the first pixel after reset has been fetched.
  assign pix_out   = loaded_q ? rd_q : 8'd0;
  assign pix_valid = pix_valid_q;
  assign proc_en   = (state_q == S_PROCESS);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_pixel_streamer.sv
// Self-checking bench for pixel_streamer on a 4x3 frame; reference is a plain frame array
// plus the expected cycle timeline of a transaction.
module tb_pixel_streamer;
  localparam int W  = 4;
  localparam int D  = 3;
  localparam int T  = W * D;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst, wr_en, start, finish_in;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [7:0]    pix_out;
  logic          pix_valid, proc_en, busy, done;
`ifdef PIXEL_STREAMER_STALL_EN
  logic          stall;
`endif

  pixel_streamer #(.WIDTH(W), .DEPTH(D), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .finish_in(finish_in),
`ifdef PIXEL_STREAMER_STALL_EN
    .stall(stall),
`endif
    .pix_out(pix_out), .pix_valid(pix_valid), .proc_en(proc_en), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] ref_mem [T];

  // Observations of the last transaction, cycle c = outputs after the c-th edge from start.
  logic [7:0] got [$];
  int first_cyc, last_cyc, gaps, proc_cyc, proc_len, overlap, done_cnt, done_cyc;
  bit busy_low, timed_out;

  task automatic write_px(input int a, input logic [7:0] v);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a[AW-1:0]; wr_data = v;
    @(negedge clk);
    wr_en = 1'b0;
    if (a < T) ref_mem[a] = v;
  endtask

  task automatic do_txn(input int fin_delay, input int stall_at, input int stall_len,
                        input bit poke_start, input bit poke_wr, input bit wr_at_start);
    int c;
    bit seen_done;
    got.delete();
    first_cyc = -1; last_cyc = -1; gaps = 0; proc_cyc = -1; proc_len = 0; overlap = 0;
    done_cnt = 0; done_cyc = -1; busy_low = 0; timed_out = 0; seen_done = 0;
    @(negedge clk);
    start = 1'b1;
    finish_in = (fin_delay == 0);
    if (wr_at_start) begin
      wr_en = 1'b1; wr_addr = '0; wr_data = ref_mem[0] ^ 8'hA5;
      ref_mem[0] = ref_mem[0] ^ 8'hA5;
    end
    for (c = 0; c < 200; c++) begin
      @(negedge clk);
      start = 1'b0; wr_en = 1'b0;
`ifdef PIXEL_STREAMER_STALL_EN
      stall = 1'b0;
`endif
      if (pix_valid) begin
        got.push_back(pix_out);
        if (first_cyc < 0) first_cyc = c;
        else gaps += c - last_cyc - 1;
        last_cyc = c;
      end
      if (pix_valid && proc_en) overlap++;
      if (proc_en) begin
        if (proc_cyc < 0) proc_cyc = c;
        proc_len++;
      end
      if (seen_done && !done) begin
        busy_low = !busy;
        break;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
        finish_in = 1'b0;
        seen_done = 1'b1;
      end
      if (fin_delay > 0 && proc_en && proc_len == fin_delay) finish_in = 1'b1;
      if (poke_start && (c == 4 || c == T + 2)) start = 1'b1;
      if (poke_wr && c == 3) begin
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = ~ref_mem[2];
      end
`ifdef PIXEL_STREAMER_STALL_EN
      if (c >= stall_at && c < stall_at + stall_len) stall = 1'b1;
`endif
    end
    if (c >= 200) timed_out = 1'b1;
    finish_in = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({pix_out, pix_valid, proc_en, busy, done} !== 12'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got pix_out=%0d valid=%0b proc=%0b busy=%0b done=%0b, want all 0",
               pix_out, pix_valid, proc_en, busy, done);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_stream();
    for (int i = 0; i < T; i++) write_px(i, 8'(i + 16));
    do_txn(5, 0, 0, 0, 0, 0);
    n_cmp++;
    if (timed_out) begin n_bad++; $display("FAIL stream_timeout: transaction never completed"); end
    n_cmp++;
    if (got.size() != T) begin n_bad++; $display("FAIL stream_len: got %0d pixels, want %0d", got.size(), T); end
    for (int i = 0; i < T && i < got.size(); i++) begin
      n_cmp++;
      if (got[i] !== 8'(i + 16)) begin n_bad++; $display("FAIL stream_pix[%0d]: got %0d want %0d", i, got[i], i + 16); end
    end
    n_cmp++;
    if (first_cyc != 1) begin n_bad++; $display("FAIL stream_latency: first valid at %0d, want 1", first_cyc); end
    n_cmp++;
    if (gaps != 0) begin n_bad++; $display("FAIL stream_gaps: got %0d bubbles, want 0", gaps); end
  endtask

  task automatic test_process();
    do_txn(5, 0, 0, 0, 0, 0);
    n_cmp++;
    if (proc_cyc != T + 1) begin n_bad++; $display("FAIL proc_start: proc_en rose at %0d, want %0d", proc_cyc, T + 1); end
    n_cmp++;
    if (overlap != 0) begin n_bad++; $display("FAIL proc_overlap: %0d cycles valid&proc_en, want 0", overlap); end
    n_cmp++;
    if (proc_len != 5) begin n_bad++; $display("FAIL proc_len: got %0d want 5", proc_len); end
    n_cmp++;
    if (done_cnt != 1 || done_cyc != T + 6) begin
      n_bad++; $display("FAIL done_pulse: count %0d at %0d, want 1 at %0d", done_cnt, done_cyc, T + 6);
    end
    n_cmp++;
    if (!busy_low) begin n_bad++; $display("FAIL busy_fall: busy=%0b after done, want 0", busy); end
    do_txn(0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (proc_len != 1 || done_cnt != 1) begin
      n_bad++; $display("FAIL finish_early: proc_len %0d done %0d, want 1 and 1", proc_len, done_cnt);
    end
  endtask

  task automatic test_drop_writes();
    write_px(12, 8'hEE);
    write_px(15, 8'hDD);
    do_txn(3, 0, 0, 0, 1, 0);
    do_txn(2, 0, 0, 0, 0, 0);
    n_cmp++;
    if (got.size() != T) begin n_bad++; $display("FAIL drop_len: got %0d want %0d", got.size(), T); end
    for (int i = 0; i < T && i < got.size(); i++) begin
      n_cmp++;
      if (got[i] !== ref_mem[i]) begin n_bad++; $display("FAIL drop_pix[%0d]: got %0d want %0d", i, got[i], ref_mem[i]); end
    end
  endtask

  task automatic test_start_ignored();
    do_txn(5, 0, 0, 1, 0, 0);
    n_cmp++;
    if (done_cnt != 1 || !busy_low || got.size() != T) begin
      n_bad++;
      $display("FAIL start_busy: done %0d busy_low %0b pixels %0d, want 1 1 %0d", done_cnt, busy_low, got.size(), T);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    bit hit;
    seen = 0; hit = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (pix_valid) seen++;
      if (seen == 6) begin hit = 1; break; end
      @(negedge clk);
    end
    n_cmp++;
    if (!hit || pix_out !== ref_mem[5]) begin
      n_bad++; $display("FAIL rst_mid_pix5: reached %0b pix_out %0d want %0d", hit, pix_out, ref_mem[5]);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({pix_out, pix_valid, proc_en, busy, done} !== 12'd0) begin
      n_bad++; $display("FAIL rst_mid_async: pix_out=%0d valid=%0b busy=%0b, want 0", pix_out, pix_valid, busy);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (pix_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid_resume: valid=%0b busy=%0b, want 0 0", pix_valid, busy);
    end
    do_txn(2, 0, 0, 0, 0, 0);
    n_cmp++;
    if (got.size() != T || first_cyc != 1) begin
      n_bad++; $display("FAIL rst_restream: pixels %0d first %0d, want %0d 1", got.size(), first_cyc, T);
    end
    for (int i = 0; i < T && i < got.size(); i++) begin
      n_cmp++;
      if (got[i] !== ref_mem[i]) begin n_bad++; $display("FAIL rst_pix[%0d]: got %0d want %0d", i, got[i], ref_mem[i]); end
    end
  endtask

  task automatic test_same_edge_write();
    do_txn(1, 0, 0, 0, 0, 1);
    n_cmp++;
    if (got.size() == 0 || got[0] !== ref_mem[0]) begin
      n_bad++; $display("FAIL wr_start_edge: pixel0 %0d want %0d", (got.size() > 0) ? got[0] : 8'd0, ref_mem[0]);
    end
  endtask

  task automatic test_random();
    int fd;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < T; i++) write_px(i, 8'($urandom_range(0, 255)));
      fd = $urandom_range(0, 6);
      do_txn(fd, 0, 0, 0, 0, 0);
      n_cmp++;
      if (timed_out || got.size() != T || proc_len != ((fd == 0) ? 1 : fd) || done_cnt != 1) begin
        n_bad++;
        $display("FAIL rand%0d_timeline: to %0b pixels %0d proc_len %0d done %0d (fd %0d)",
                 r, timed_out, got.size(), proc_len, done_cnt, fd);
      end
      for (int i = 0; i < T && i < got.size(); i++) begin
        n_cmp++;
        if (got[i] !== ref_mem[i]) begin n_bad++; $display("FAIL rand%0d_pix[%0d]: got %0d want %0d", r, i, got[i], ref_mem[i]); end
      end
    end
  endtask

`ifdef PIXEL_STREAMER_STALL_EN
  task automatic test_stall();
    int at, len;
    for (int r = 0; r < 3; r++) begin
      at  = (r == 0) ? 5 : $urandom_range(1, T - 1);
      len = (r == 0) ? 3 : $urandom_range(1, 4);
      do_txn(3, at, len, 0, 0, 0);
      n_cmp++;
      if (gaps != len || last_cyc != T + len || proc_cyc != T + len + 1) begin
        n_bad++;
        $display("FAIL stall%0d_timing: gaps %0d last %0d proc %0d, want %0d %0d %0d",
                 r, gaps, last_cyc, proc_cyc, len, T + len, T + len + 1);
      end
      n_cmp++;
      if (got.size() != T) begin n_bad++; $display("FAIL stall%0d_len: got %0d want %0d", r, got.size(), T); end
      for (int i = 0; i < T && i < got.size(); i++) begin
        n_cmp++;
        if (got[i] !== ref_mem[i]) begin n_bad++; $display("FAIL stall%0d_pix[%0d]: got %0d want %0d", r, i, got[i], ref_mem[i]); end
      end
    end
  endtask
`endif

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0; finish_in = 1'b0;
`ifdef PIXEL_STREAMER_STALL_EN
    stall = 1'b0;
`endif
    test_reset();
    test_stream();
    test_process();
    test_drop_writes();
    test_start_ignored();
    test_reset_mid();
    test_same_edge_write();
    test_random();
`ifdef PIXEL_STREAMER_STALL_EN
    test_stall();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
